// File: rtl/subpel_vfilt_engine.sv
// subpel_vfilt_engine: vertical 8-tap HEVC luma quarter/half/three-quarter interpolator
// fetching rows by index through a sliding window and streaming filtered rows with backpressure.
module subpel_vfilt_engine #(
    parameter int NPIX  = 15,
    parameter int PIX_W = 8,
    parameter int OUT_W = 16,
    parameter int MAX_H = 64,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDX_W-1:0]        cfg_h,
    output logic                    row_req,
    output logic [IDX_W-1:0]        row_idx,
    input  logic                    row_vld,
    input  logic [NPIX*PIX_W-1:0]   in_row,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [IDX_W-1:0]        out_idx,
    output logic [NPIX*OUT_W-1:0]   out_a,
    output logic [NPIX*OUT_W-1:0]   out_b,
    output logic [NPIX*OUT_W-1:0]   out_c,
    output logic                    busy,
    output logic                    done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam int TA [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int TB [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int TC [8] = '{0, 1, -5, 17, 58, -10, 4, -1};
    logic [1:0] state_q, state_d;
    logic [IDX_W-1:0] h_q, h_d, row_idx_q, row_idx_d, out_idx_q, out_idx_d;
    logic out_vld_q, out_vld_d, done_q, done_d, load;
    logic [NPIX*PIX_W-1:0] win_q [7];
    logic [NPIX*PIX_W-1:0] rows [8];
    logic [NPIX*OUT_W-1:0] a_q, b_q, c_q, fa, fb, fc;
    logic signed [OUT_W-1:0] sa, sb, sc;
    int pix;
    logic in_xfer, out_xfer;
    assign row_req  = (state_q == FILL) || (state_q == RUN && (!out_vld_q || out_rdy));
    assign in_xfer  = row_req && row_vld;
    assign out_xfer = out_vld_q && out_rdy;
    assign row_idx  = row_idx_q;
    assign out_vld  = out_vld_q;
    assign out_idx  = out_idx_q;
    assign out_a    = a_q;
    assign out_b    = b_q;
    assign out_c    = c_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    // The incoming row completes the 8-row window, so filtering happens on the accept edge.
    always_comb begin
        for (int k = 0; k < 7; k++) rows[k] = win_q[k];
        rows[7] = in_row;
    end
    always_comb begin
        fa = '0;
        fb = '0;
        fc = '0;
        sa = '0;
        sb = '0;
        sc = '0;
        pix = 0;
        for (int x = 0; x < NPIX; x++) begin
            sa = '0;
            sb = '0;
            sc = '0;
            for (int k = 0; k < 8; k++) begin
                pix = int'(rows[k][x*PIX_W +: PIX_W]);
                sa += OUT_W'(TA[k] * pix);
                sb += OUT_W'(TB[k] * pix);
                sc += OUT_W'(TC[k] * pix);
            end
            fa[x*OUT_W +: OUT_W] = sa;
            fb[x*OUT_W +: OUT_W] = sb;
            fc[x*OUT_W +: OUT_W] = sc;
        end
    end
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        row_idx_d = row_idx_q;
        out_idx_d = out_idx_q;
        out_vld_d = out_vld_q && !out_rdy;
        done_d    = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: if (start && cfg_h != '0) begin
                h_d       = (cfg_h > IDX_W'(MAX_H)) ? IDX_W'(MAX_H) : cfg_h;
                row_idx_d = '0;
                state_d   = FILL;
            end
            FILL: if (in_xfer) begin
                row_idx_d = row_idx_q + 1'b1;
                state_d   = (row_idx_q == IDX_W'(6)) ? RUN : FILL;
            end
            RUN: if (in_xfer) begin
                row_idx_d = row_idx_q + 1'b1;
                out_idx_d = row_idx_q - IDX_W'(7);
                out_vld_d = 1'b1;
                load      = 1'b1;
                state_d   = (row_idx_q == h_q + IDX_W'(6)) ? DRAIN : RUN;
            end
            default: if (out_xfer) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            h_q       <= '0;
            row_idx_q <= '0;
            out_idx_q <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            for (int k = 0; k < 7; k++) win_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            row_idx_q <= row_idx_d;
            out_idx_q <= out_idx_d;
            out_vld_q <= out_vld_d;
            done_q    <= done_d;
            if (in_xfer) for (int k = 0; k < 7; k++) win_q[k] <= rows[k+1];
            if (load) begin
                a_q <= fa;
                b_q <= fb;
                c_q <= fc;
            end
        end
    end
endmodule

// File: tb/tb_subpel_vfilt_engine.sv
// tb_subpel_vfilt_engine: directed vector table plus hand-written reset/config sequences.
module tb_subpel_vfilt_engine;
    localparam int NPIX = 15;
    localparam int OW = NPIX * 16;
    typedef struct {
        int pat;
        int h;
        int nouts;
        int a0;
        int b0;
        int c0;
        int dr;
        int dx;
        bit gap;
        int stall;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, row_vld = 1'b0, out_rdy = 1'b1;
    logic [7:0] cfg_h = '0;
    logic row_req, out_vld, busy, done;
    logic [7:0] row_idx, out_idx;
    logic [NPIX*8-1:0] in_row;
    logic [OW-1:0] out_a, out_b, out_c;
    int pat = 0;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [9];
    subpel_vfilt_engine dut (
        .clk(clk), .rst(rst), .start(start), .cfg_h(cfg_h),
        .row_req(row_req), .row_idx(row_idx), .row_vld(row_vld), .in_row(in_row),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // Patterns: 0 flat, 1 step at row 4, 2/3 impulse at row 2/3, 4 vertical ramp, 5 horizontal ramp.
    function automatic logic [7:0] pix(input int p, input int r, input int x);
        int v;
        v = (p == 0) ? 100 : (p == 1) ? ((r >= 4) ? 64 : 0) : (p == 2) ? ((r == 2) ? 255 : 0) :
            (p == 3) ? ((r == 3) ? 255 : 0) : (p == 4) ? r * 8 : x * 10;
        return v[7:0];
    endfunction
    always_comb for (int x = 0; x < NPIX; x++) in_row[x*8 +: 8] = pix(pat, int'(row_idx), x);
    function automatic logic [OW-1:0] expv(input int f0, input int dr, input int dx, input int r);
        logic [OW-1:0] e;
        int v;
        e = '0;
        for (int x = 0; x < NPIX; x++) begin
            v = f0 + r * dr + x * dx;
            e[x*16 +: 16] = v[15:0];
        end
        return e;
    endfunction
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic run_block(input vec_t v, input string tag);
        int nin, nout, acc7, last_out, stall_left;
        bit stalled, got_done, first_seen;
        nin = 0; nout = 0; acc7 = -10; last_out = -10; stall_left = 0;
        stalled = 0; got_done = 0; first_seen = 0;
        pat = v.pat;
        @(negedge clk);
        start = 1'b1;
        cfg_h = 8'(v.h);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (out_vld && !stalled && v.stall > 0) begin
                stall_left = v.stall;
                stalled = 1;
            end
            out_rdy = (stall_left == 0);
            row_vld = v.gap ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (stall_left > 0) begin
                chk({tag, " stall_row_req"}, row_req, 0);
                chk({tag, " stall_out_idx"}, out_idx, 0);
                chk({tag, " stall_out_a"}, out_a, expv(v.a0, v.dr, v.dx, 0));
                stall_left--;
            end
            if (out_vld && !first_seen) begin
                first_seen = 1;
                chk({tag, " latency"}, cyc, acc7 + 1);
            end
            if (row_req && row_vld) begin
                chk({tag, " row_idx"}, row_idx, nin);
                if (nin == 7) acc7 = cyc;
                nin++;
            end
            if (out_vld && out_rdy) begin
                chk({tag, " out_idx"}, out_idx, nout);
                chk({tag, " out_a"}, out_a, expv(v.a0, v.dr, v.dx, nout));
                chk({tag, " out_b"}, out_b, expv(v.b0, v.dr, v.dx, nout));
                chk({tag, " out_c"}, out_c, expv(v.c0, v.dr, v.dx, nout));
                last_out = cyc;
                nout++;
            end
            if (done) begin
                got_done = 1;
                chk({tag, " done_timing"}, cyc, last_out + 1);
                chk({tag, " busy_at_done"}, busy, 0);
                chk({tag, " n_outputs"}, nout, v.nouts);
                chk({tag, " n_inputs"}, nin, v.nouts + 7);
            end
            @(negedge clk);
        end
        if (got_done) begin
            #1;
            chk({tag, " done_one_cycle"}, done, 0);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no done, required done within 300 cycles", tag);
        end
        row_vld = 1'b0;
        out_rdy = 1'b1;
    endtask
    initial begin
        int nout;
        bit seen_done;
        vecs[0] = '{0, 4, 4, 6400, 6400, 6400, 0, 0, 1'b0, 0};
        vecs[1] = '{1, 1, 1, 832, 2048, 3264, 0, 0, 1'b0, 0};
        vecs[2] = '{2, 1, 1, -2550, -2805, -1275, 0, 0, 1'b0, 0};
        vecs[3] = '{3, 1, 1, 14790, 10200, 4335, 0, 0, 1'b0, 0};
        vecs[4] = '{4, 4, 4, 1656, 1792, 1928, 512, 0, 1'b0, 0};
        vecs[5] = '{5, 3, 3, 0, 0, 0, 0, 640, 1'b0, 0};
        vecs[6] = '{0, 4, 4, 6400, 6400, 6400, 0, 0, 1'b1, 0};
        vecs[7] = '{0, 4, 4, 6400, 6400, 6400, 0, 0, 1'b0, 5};
        vecs[8] = '{0, 69, 64, 6400, 6400, 6400, 0, 0, 1'b0, 0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_row_req", row_req, 0);
        chk("reset_row_idx", row_idx, 0);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_out_abc", {out_a, out_b, out_c} != '0, 0);
        chk("reset_busy_done", {busy, done}, 0);
        for (int i = 0; i < 9; i++) run_block(vecs[i], $sformatf("vec%0d", i));
        // A zero-height start must be ignored.
        @(negedge clk);
        start = 1'b1;
        cfg_h = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("h0_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("h0_busy_later", busy, 0);
        chk("h0_row_req", row_req, 0);
        // Abort with reset once output 1 has been accepted.
        pat = 0;
        nout = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_h = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            out_rdy = 1'b1;
            row_vld = 1'b1;
            #1;
            if (out_vld && out_rdy) nout++;
            if (nout == 2) break;
            @(negedge clk);
        end
        chk("rst_mid_setup", nout, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_vld", out_vld, 0);
        chk("rst_mid_out_abc", {out_a, out_b, out_c} != '0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_row_req", row_req, 0);
        chk("rst_mid_idx", {row_idx, out_idx}, 0);
        seen_done = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            seen_done |= done;
            @(negedge clk);
            #1;
        end
        chk("rst_mid_no_done", seen_done, 0);
        row_vld = 1'b0;
        run_block(vecs[0], "after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
